// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the EX-stage integer ALU:
//     - alu_op_t       : 4-bit operation encoding driven by the decoder
//     - BRANCH_DEFAULT : value placed on result for branch-compare ops
//     - SHAMT_W        : width of the in-range shift amount (0..31)
//     - is_branch_op() : true for the four branch-compare encodings
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_MUL  = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_MULH = 4'b1011,
        ALU_BEQ  = 4'b1100,
        ALU_BNE  = 4'b1101,
        ALU_BGT  = 4'b1110,
        ALU_BLT  = 4'b1111
    } alu_op_t;

    // Branch-compare ops carry no arithmetic result; downstream logic sees
    // all ones so an accidental write-back is easy to spot.
    localparam logic [31:0] BRANCH_DEFAULT = 32'hFFFF_FFFF;

    // Amounts 0..31 are applied directly; anything larger saturates.
    localparam int SHAMT_W = 5;

    // The branch-compare ops occupy the top quarter of the encoding space.
    function automatic logic is_branch_op(input alu_op_t op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
//   Purely combinational barrel shifter for SLL / SRL / SRA.
//   The shift amount is the full 32-bit operand B taken as unsigned, so
//   amounts of 32 or more saturate: logical shifts give zero, arithmetic
//   right shift gives 32 copies of the sign bit.
//
//   Ports
//     operand_i  in  32  value to be shifted (operand A)
//     amount_i   in  32  unsigned shift amount (operand B, full width)
//     op_i       in   4  operation select; only SLL/SRL/SRA are meaningful
//     result_o   out 32  shifted value (zero for any non-shift op)
// ---------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
(
    input  logic [31:0] operand_i,
    input  logic [31:0] amount_i,
    input  alu_op_t     op_i,
    output logic [31:0] result_o
);

    logic               saturate;
    logic [SHAMT_W-1:0] shamt;
    logic [31:0]        sll_val;
    logic [31:0]        srl_val;
    logic [31:0]        sra_val;
    logic [31:0]        sign_fill;

    // Any set bit above bit 4 means the amount is at least 32.
    assign saturate  = |amount_i[31:SHAMT_W];
    assign shamt     = amount_i[SHAMT_W-1:0];
    assign sign_fill = {32{operand_i[31]}};

    // In-range shifts use only the low five bits; saturation overrides them
    // so that e.g. an amount of 33 is not mistaken for a shift by 1.
    assign sll_val = saturate ? 32'd0     : (operand_i << shamt);
    assign srl_val = saturate ? 32'd0     : (operand_i >> shamt);
    assign sra_val = saturate ? sign_fill : 32'($signed(operand_i) >>> shamt);

    always_comb begin
        result_o = 32'd0;
        case (op_i)
            ALU_SLL: result_o = sll_val;
            ALU_SRL: result_o = srl_val;
            ALU_SRA: result_o = sra_val;
            default: result_o = 32'd0;
        endcase
    end

endmodule : alu_shifter

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Single-cycle RV32-style integer ALU for the EX stage. Produces the
//   arithmetic/logic/shift/compare/multiply/LUI result and the branch-taken
//   flag combinationally, and keeps an EX/MEM registered copy of both.
//
//   Ports
//     clk       in   1  system clock; rising edge updates registered copies
//     rst       in   1  asynchronous active-high reset (registered copies only)
//     a         in  32  operand A (rs1), two's complement
//     b         in  32  operand B (rs2 or immediate), two's complement
//     alu_op    in   4  operation select (alu_op_t encoding)
//     result    out 32  combinational result
//     branch    out  1  combinational branch-taken flag
//     result_q  out 32  result registered on clk
//     branch_q  out  1  branch registered on clk
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_op,
    output logic [31:0] result,
    output logic        branch,
    output logic [31:0] result_q,
    output logic        branch_q
);

    alu_op_t            op;
    logic [31:0]        shift_res;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] product;
    logic               eq;
    logic               lt_s;
    logic               gt_s;
    logic [31:0]        result_d;
    logic               branch_d;

    assign op = alu_op_t'(alu_op);

    // -----------------------------------------------------------------------
    // Shifts, with full-width amount saturation
    // -----------------------------------------------------------------------
    alu_shifter u_shifter (
        .operand_i (a),
        .amount_i  (b),
        .op_i      (op),
        .result_o  (shift_res)
    );

    // -----------------------------------------------------------------------
    // One signed 64-bit multiplier shared by MUL (low word) and MULH (high
    // word). Operands are sign-extended up front so the product is exact.
    // -----------------------------------------------------------------------
    assign a_ext   = {{32{a[31]}}, a};
    assign b_ext   = {{32{b[31]}}, b};
    assign product = a_ext * b_ext;

    // -----------------------------------------------------------------------
    // Comparators shared between SLT and the branch conditions.
    // -----------------------------------------------------------------------
    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign gt_s = ($signed(a) > $signed(b));

    // -----------------------------------------------------------------------
    // Result / branch selection
    // -----------------------------------------------------------------------
    always_comb begin
        result_d = 32'd0;
        branch_d = 1'b0;

        // Branch-compare ops never produce a data result.
        if (is_branch_op(op)) begin
            result_d = BRANCH_DEFAULT;
        end

        case (op)
            ALU_ADD:  result_d = a + b;
            ALU_SUB:  result_d = a - b;
            ALU_XOR:  result_d = a ^ b;
            ALU_OR:   result_d = a | b;
            ALU_AND:  result_d = a & b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result_d = shift_res;
            ALU_SLT:  result_d = {31'd0, lt_s};
            ALU_MUL:  result_d = product[31:0];
            // Upper twelve bits of b fall off the top.
            ALU_LUI:  result_d = {b[19:0], 12'd0};
            ALU_MULH: result_d = product[63:32];
            ALU_BEQ:  branch_d = eq;
            ALU_BNE:  branch_d = ~eq;
            ALU_BGT:  branch_d = gt_s;
            ALU_BLT:  branch_d = lt_s;
            default: begin
                result_d = 32'd0;
                branch_d = 1'b0;
            end
        endcase
    end

    assign result = result_d;
    assign branch = branch_d;

    // -----------------------------------------------------------------------
    // EX/MEM copy. Reset clears only the registered outputs; the
    // combinational path is independent of rst.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
            branch_q <= 1'b0;
        end else begin
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

endmodule : alu

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [31:0] result;
    logic        branch;
    logic [31:0] result_q;
    logic        branch_q;

    int checks;
    int passed;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .result   (result),
        .branch   (branch),
        .result_q (result_q),
        .branch_q (branch_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_res;
        logic        exp_br;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    // Independent reference: shifts done one bit at a time, multiply via
    // 64-bit longint, compares via signed int.
    function automatic logic [32:0] ref_model(input logic [3:0] op,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        logic [31:0] r;
        logic        br;
        longint      p;
        int          n;
        int          sx;
        int          sy;
        r  = 32'd0;
        br = 1'b0;
        sx = int'(x);
        sy = int'(y);
        n  = (y > 32'd40) ? 40 : int'(y);
        p  = longint'(sx) * longint'(sy);
        case (op)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x ^ y;
            4'd3:  r = x | y;
            4'd4:  r = x & y;
            4'd5:  begin r = x; for (int i = 0; i < n; i++) r = {r[30:0], 1'b0}; end
            4'd6:  begin r = x; for (int i = 0; i < n; i++) r = {1'b0, r[31:1]}; end
            4'd7:  begin r = x; for (int i = 0; i < n; i++) r = {r[31], r[31:1]}; end
            4'd8:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd9:  r = p[31:0];
            4'd10: r = y * 32'd4096;
            4'd11: r = p[63:32];
            4'd12: begin r = 32'hFFFF_FFFF; br = (x == y); end
            4'd13: begin r = 32'hFFFF_FFFF; br = (x != y); end
            4'd14: begin r = 32'hFFFF_FFFF; br = (sx > sy); end
            default: begin r = 32'hFFFF_FFFF; br = (sx < sy); end
        endcase
        return {br, r};
    endfunction

    initial begin
        logic [32:0] expv;
        checks = 0;
        passed = 0;

        vecs.push_back('{"add_ovf",   ALU_ADD,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0});
        vecs.push_back('{"sub_wrap",  ALU_SUB,  32'h0,         32'h1,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"xor",       ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'hFF00_FF00, 1'b0});
        vecs.push_back('{"or",        ALU_OR,   32'h1234_0000, 32'h0000_5678,  32'h1234_5678, 1'b0});
        vecs.push_back('{"and",       ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F,  32'h0F00_0F00, 1'b0});
        vecs.push_back('{"sll31",     ALU_SLL,  32'h1,         32'd31,         32'h8000_0000, 1'b0});
        vecs.push_back('{"sll32",     ALU_SLL,  32'h1,         32'd32,         32'h0,         1'b0});
        vecs.push_back('{"sll33",     ALU_SLL,  32'h1,         32'd33,         32'h0,         1'b0});
        vecs.push_back('{"srl4",      ALU_SRL,  32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0});
        vecs.push_back('{"srl40",     ALU_SRL,  32'hFFFF_FFFF, 32'd40,         32'h0,         1'b0});
        vecs.push_back('{"sra4",      ALU_SRA,  32'h8000_0000, 32'd4,          32'hF800_0000, 1'b0});
        vecs.push_back('{"sra40",     ALU_SRA,  32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"sra_pos",   ALU_SRA,  32'h7FFF_FFFF, 32'd100,        32'h0,         1'b0});
        vecs.push_back('{"sra_big",   ALU_SRA,  32'h4000_0000, 32'h8000_0001,  32'h0,         1'b0});
        vecs.push_back('{"slt_m1_0",  ALU_SLT,  32'hFFFF_FFFF, 32'h0,          32'h1,         1'b0});
        vecs.push_back('{"slt_0_m1",  ALU_SLT,  32'h0,         32'hFFFF_FFFF,  32'h0,         1'b0});
        vecs.push_back('{"slt_ext",   ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF,  32'h1,         1'b0});
        vecs.push_back('{"mul_m3_5",  ALU_MUL,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFF1, 1'b0});
        vecs.push_back('{"mulh_m3_5", ALU_MULH, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"mul_min",   ALU_MUL,  32'h8000_0000, 32'h8000_0000,  32'h0,         1'b0});
        vecs.push_back('{"mulh_min",  ALU_MULH, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 1'b0});
        vecs.push_back('{"mul_max",   ALU_MUL,  32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h1,         1'b0});
        vecs.push_back('{"mulh_max",  ALU_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 1'b0});
        vecs.push_back('{"lui",       ALU_LUI,  32'hDEAD_BEEF, 32'h0001_2345,  32'h1234_5000, 1'b0});
        vecs.push_back('{"lui_trunc", ALU_LUI,  32'h0,         32'hFFFF_FFFF,  32'hFFFF_F000, 1'b0});
        vecs.push_back('{"beq_55",    ALU_BEQ,  32'h55,        32'h55,         32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"beq_0",     ALU_BEQ,  32'h0,         32'h0,          32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"beq_min",   ALU_BEQ,  32'h8000_0000, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"beq_ne",    ALU_BEQ,  32'h1,         32'h2,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"bne_eq",    ALU_BNE,  32'h8000_0000, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"bne_ne",    ALU_BNE,  32'h1,         32'h2,          32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"bgt_m1_0",  ALU_BGT,  32'hFFFF_FFFF, 32'h0,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"bgt_eq",    ALU_BGT,  32'h5,         32'h5,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"bgt_ext",   ALU_BGT,  32'h7FFF_FFFF, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"blt_m1_0",  ALU_BLT,  32'hFFFF_FFFF, 32'h0,          32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"blt_eq",    ALU_BLT,  32'h5,         32'h5,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"blt_ext",   ALU_BLT,  32'h8000_0000, 32'h7FFF_FFFF,  32'hFFFF_FFFF, 1'b1});

        // Reset state: drive non-zero inputs, registered copies must be 0.
        rst    = 1'b1;
        a      = 32'h55;
        b      = 32'h55;
        alu_op = 4'(ALU_BEQ);
        #2;
        check32("reset_result_q", result_q, 32'h0);
        check1 ("reset_branch_q", branch_q, 1'b0);
        check1 ("reset_comb_branch", branch, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            alu_op = vecs[i].op;
            a      = vecs[i].va;
            b      = vecs[i].vb;
            #1;
            check32({vecs[i].name, "_res"}, result, vecs[i].exp_res);
            check1 ({vecs[i].name, "_br"},  branch, vecs[i].exp_br);
            $display("vec %-10s op=%h a=%08h b=%08h result=%08h branch=%0b",
                     vecs[i].name, alu_op, a, b, result, branch);
        end

        // Op switch from taken BLT to ADD: branch drops with no clock edge.
        @(negedge clk);
        alu_op = 4'(ALU_BLT); a = 32'hFFFF_FFFF; b = 32'h0;
        #1;
        check1("switch_blt_taken", branch, 1'b1);
        alu_op = 4'(ALU_ADD);
        #1;
        check1 ("switch_add_branch", branch, 1'b0);
        check32("switch_add_result", result, 32'hFFFF_FFFF);
        $display("seq op_switch branch=%0b result=%08h", branch, result);

        // Registered copy: one-cycle latency.
        @(negedge clk);
        alu_op = 4'(ALU_ADD); a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        check32("reg_add_result_q", result_q, 32'd5);
        check1 ("reg_add_branch_q", branch_q, 1'b0);
        @(negedge clk);
        alu_op = 4'(ALU_BEQ); a = 32'h55; b = 32'h55;
        #1;
        check32("reg_latency_hold", result_q, 32'd5);
        @(posedge clk); #1;
        check32("reg_beq_result_q", result_q, 32'hFFFF_FFFF);
        check1 ("reg_beq_branch_q", branch_q, 1'b1);
        $display("seq registered result_q=%08h branch_q=%0b", result_q, branch_q);

        // Asynchronous reset mid-cycle; combinational path unaffected.
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check32("async_rst_result_q", result_q, 32'h0);
        check1 ("async_rst_branch_q", branch_q, 1'b0);
        check32("async_rst_comb_res", result, 32'hFFFF_FFFF);
        check1 ("async_rst_comb_br",  branch, 1'b1);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check32("post_rst_result_q", result_q, 32'hFFFF_FFFF);
        check1 ("post_rst_branch_q", branch_q, 1'b1);
        $display("seq async_reset release result_q=%08h branch_q=%0b", result_q, branch_q);

        // Random regression against the reference model.
        for (int op_i = 0; op_i < 16; op_i++) begin
            int errs;
            errs = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                alu_op = 4'(op_i);
                a = $urandom;
                if (k % 4 == 0) b = a;
                else if (k % 2 == 0) b = 32'($urandom_range(0, 40));
                else b = $urandom;
                #1;
                expv = ref_model(alu_op, a, b);
                checks++;
                if (result === expv[31:0] && branch === expv[32]) passed++;
                else begin
                    errs++;
                    $display("FAIL rand_op%0d: a=%08h b=%08h got %08h/%0b expected %08h/%0b",
                             op_i, a, b, result, branch, expv[31:0], expv[32]);
                end
            end
            $display("rand op=%0d vectors=60 errors=%0d", op_i, errs);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_alu
